brent_kung_pipe: RTL and testbench
==================================

BRENT_KUNG_PIPE -- requirements
Module: brent_kung_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/sum width; a power of two, 8..64.
REQ-002 SHALL have parameter TAG_W, default 4: width of the sideband tag carried alongside each operation.
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock, all state on clk.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  addend A.
REQ-008 SHALL have port b  input  WIDTH  addend B.
REQ-009 SHALL have port cin  input  1  carry in.
REQ-010 SHALL have port in_tag  input  TAG_W  sideband tag, returned unchanged with its result.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
REQ-014 SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-015 SHALL have port out_tag  output  TAG_W  tag of the result.

Function
REQ-016 SHALL compute carries with a Brent-Kung prefix network: log2(WIDTH) up-sweep levels, then log2(WIDTH)-1 down-sweep levels; cin is folded in as generate at position -1.
REQ-017 SHALL use a 3-stage pipeline: S1 registers bitwise g=a&b, p=a^b, cin and tag; S2 registers the up-sweep group (G,P); S3 registers the completed carries, sum=p^carry, and cout.
REQ-018 SHALL accept an operation when in_valid and in_ready are both high on a rising edge.
REQ-019 SHALL present an accepted operation on sum/cout/out_tag with out_valid high exactly 3 cycles after acceptance, provided no stall occurs.
REQ-020 SHALL derive a global advance enable adv = !out_valid | out_ready; all stages load when adv is high and hold when adv is low.
REQ-021 SHALL drive in_ready = adv, combinationally.
REQ-022 SHALL keep sum, cout, out_tag and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL propagate a per-stage valid bit; a stage loaded while in_valid=0 (a bubble) SHALL not raise out_valid when it reaches S3.
REQ-024 SHALL sustain one result per cycle when in_valid=1 and out_ready=1 continuously.
REQ-025 SHALL collapse bubbles during a stall only via adv; intermediate bubbles are not compressed.
REQ-026 SHALL deliver results in acceptance order, with no loss or duplication.
REQ-027 SHALL produce exact modular sums at the extremes: all-ones+0+1 -> sum 0, cout 1; 0+0+0 -> sum 0, cout 0.

Reset
REQ-028 SHALL clear all stage valid bits, sum, cout and out_tag to 0 when rst is high at a rising edge, regardless of adv.
REQ-029 SHALL drive out_valid=0 and in_ready=1 in the cycle after reset.
REQ-030 SHALL discard any in-flight operations on a reset asserted mid-operation, and SHALL not accept an operation on a cycle where rst is high.

Configuration
REQ-031 SHALL, with BRENT_KUNG_PIPE_OVF_EN defined, add output port ovf (1 bit), registered in S3, equal to the signed two's-complement overflow (carry into MSB xor cout), reset to 0 and held under stall like sum.
REQ-032 SHALL, without BRENT_KUNG_PIPE_OVF_EN, have no ovf port; all other behaviour SHALL be identical.

Verification
REQ-033 SHALL cover: WIDTH=32, a=0x12345678, b=0x11111111, cin=0, tag=3 -> 3 cycles later sum=0x23456789, cout=0, out_tag=3.
REQ-034 SHALL cover: a=0xFFFFFFFF, b=0, cin=1 -> sum=0x00000000, cout=1; with OVF_EN, ovf=0.
REQ-035 SHALL cover: a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0; with OVF_EN, ovf=1.
REQ-036 SHALL cover: 8 back-to-back operations with out_ready=1 -> 8 consecutive out_valid cycles in order, tags 0..7.
REQ-037 SHALL cover: out_ready=0 for 5 cycles while holding a result -> in_ready=0, outputs frozen; on release, remaining results drain in order with none lost.
REQ-038 SHALL cover: rst asserted with 3 operations in flight -> next cycle out_valid=0, sum=0, in_ready=1; none of the 3 results ever appear; then rerun REQ-033 with WIDTH=8 and WIDTH=64 for random a/b/cin against a+b+cin.

Source files
------------

// File: rtl/brent_kung_pipe.sv
// Three-stage Brent-Kung adder with valid/ready flow control and a tag.
// Define BRENT_KUNG_PIPE_OVF_EN to add the registered signed-overflow output.
module brent_kung_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [TAG_W-1:0] out_tag
`ifdef BRENT_KUNG_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int LOG = $clog2(WIDTH);

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic             c;
    logic [TAG_W-1:0] t;
  } s1_t;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] gp;
    logic [WIDTH-1:0] p;
    logic             c;
    logic [TAG_W-1:0] t;
  } s2_t;

  s1_t s1;
  s2_t s2;
  logic adv;
  logic [WIDTH-1:0] ug, up, dg, carry;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Nodes combined at up-sweep level l: every 2^l-th bit.
  function automatic logic [WIDTH-1:0] upmask(input int l);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      m = {m[WIDTH-2:0], ((i + 1) % (1 << l)) == 0};
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] dnmask(input int l);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      m = {m[WIDTH-2:0],
           (i >= (1 << l)) &&
           (((i + 1) % (1 << l)) == (1 << (l - 1)))};
    return m;
  endfunction

  // cin enters as the generate of position -1, folded into bit 0.
  always_comb begin
    ug = s1.g | {{(WIDTH-1){1'b0}}, s1.p[0] & s1.c};
    up = {s1.p[WIDTH-1:1], 1'b0};
    for (int l = 1; l <= LOG; l++) begin
      ug = ug | (upmask(l) & up & (ug << (1 << (l - 1))));
      up = (up & ~upmask(l)) |
           (upmask(l) & up & (up << (1 << (l - 1))));
    end
  end

  always_comb begin
    dg = s2.gg;
    for (int l = LOG - 1; l >= 1; l--)
      dg = dg | (dnmask(l) & s2.gp & (dg << (1 << (l - 1))));
    carry = {dg[WIDTH-2:0], s2.c};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      out_tag   <= '0;
`ifdef BRENT_KUNG_PIPE_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (adv) begin
      s1 <= '{v: in_valid, g: a & b, p: a ^ b,
              c: cin, t: in_tag};
      s2 <= '{v: s1.v, gg: ug, gp: up, p: s1.p,
              c: s1.c, t: s1.t};
      out_valid <= s2.v;
      sum       <= s2.p ^ carry;
      cout      <= dg[WIDTH-1];
      out_tag   <= s2.t;
`ifdef BRENT_KUNG_PIPE_OVF_EN
      ovf       <= dg[WIDTH-1] ^ dg[WIDTH-2];
`endif
    end
  end

endmodule

// File: tb/tb_brent_kung_pipe.sv
// Scoreboard bench for brent_kung_pipe at WIDTH 32, 8 and 64.
// Honours BRENT_KUNG_PIPE_OVF_EN when checking the overflow output.
module tb_brent_kung_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic [3:0]  t;
    logic        o;
    int          at;
    bit          lat;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t q64[$];

  logic v32 = 0, r32, ov32, or32 = 1, ci32 = 0, co32;
  logic [31:0] a32 = 0, b32 = 0, s32;
  logic [3:0] ti32 = 0, to32;
  logic v8 = 0, r8, ov8, or8 = 1, ci8 = 0, co8;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic [3:0] ti8 = 0, to8;
  logic v64 = 0, r64, ov64, or64 = 1, ci64 = 0, co64;
  logic [63:0] a64 = 0, b64 = 0, s64;
  logic [3:0] ti64 = 0, to64;
`ifdef BRENT_KUNG_PIPE_OVF_EN
  logic f32, f8, f64;
`endif

  brent_kung_pipe #(.WIDTH(32), .TAG_W(4)) u32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32),
    .a(a32), .b(b32), .cin(ci32), .in_tag(ti32),
    .out_valid(ov32), .out_ready(or32), .sum(s32),
    .cout(co32), .out_tag(to32)
`ifdef BRENT_KUNG_PIPE_OVF_EN
    , .ovf(f32)
`endif
  );

  brent_kung_pipe #(.WIDTH(8), .TAG_W(4)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8),
    .a(a8), .b(b8), .cin(ci8), .in_tag(ti8),
    .out_valid(ov8), .out_ready(or8), .sum(s8),
    .cout(co8), .out_tag(to8)
`ifdef BRENT_KUNG_PIPE_OVF_EN
    , .ovf(f8)
`endif
  );

  brent_kung_pipe #(.WIDTH(64), .TAG_W(4)) u64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64),
    .a(a64), .b(b64), .cin(ci64), .in_tag(ti64),
    .out_valid(ov64), .out_ready(or64), .sum(s64),
    .cout(co64), .out_tag(to64)
`ifdef BRENT_KUNG_PIPE_OVF_EN
    , .ovf(f64)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  function automatic exp_t model(input int w, input logic [63:0] a,
                                 input logic [63:0] b, input logic c,
                                 input logic [3:0] t, input bit lat);
    logic [64:0] full;
    logic [63:0] mask;
    logic sa, sb, ss;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    full = {1'b0, a} + {1'b0, b} + 65'(c);
    e.s = full[63:0] & mask;
    e.c = 1'(full >> w);
    sa = 1'(a >> (w - 1));
    sb = 1'(b >> (w - 1));
    ss = 1'(e.s >> (w - 1));
    e.o = (sa == sb) && (ss != sa);
    e.t = t;
    e.at = cyc;
    e.lat = lat;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    #3;
    if (!rst && ov32 && or32) begin
      if (q32.size() == 0) miss("m32 unexpected result");
      else begin
        e = q32.pop_front();
        chk("m32 sum", 64'(s32), e.s);
        chk("m32 cout", 64'(co32), 64'(e.c));
        chk("m32 tag", 64'(to32), 64'(e.t));
`ifdef BRENT_KUNG_PIPE_OVF_EN
        chk("m32 ovf", 64'(f32), 64'(e.o));
`endif
        if (e.lat) chk("m32 latency", 64'(cyc - e.at), 64'd3);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #3;
    if (!rst && ov8 && or8) begin
      if (q8.size() == 0) miss("m8 unexpected result");
      else begin
        e = q8.pop_front();
        chk("m8 sum", 64'(s8), e.s);
        chk("m8 cout", 64'(co8), 64'(e.c));
        chk("m8 tag", 64'(to8), 64'(e.t));
`ifdef BRENT_KUNG_PIPE_OVF_EN
        chk("m8 ovf", 64'(f8), 64'(e.o));
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #3;
    if (!rst && ov64 && or64) begin
      if (q64.size() == 0) miss("m64 unexpected result");
      else begin
        e = q64.pop_front();
        chk("m64 sum", s64, e.s);
        chk("m64 cout", 64'(co64), 64'(e.c));
        chk("m64 tag", 64'(to64), 64'(e.t));
`ifdef BRENT_KUNG_PIPE_OVF_EN
        chk("m64 ovf", 64'(f64), 64'(e.o));
`endif
      end
    end
  end

  task automatic send32(input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic [3:0] t,
                        input logic [31:0] es, input logic ec,
                        input logic eo, input bit lat);
    bit done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      v32 = 1; a32 = a; b32 = b; ci32 = c; ti32 = t;
      #1;
      if (r32 && !rst) begin
        q32.push_back('{s: 64'(es), c: ec, t: t, o: eo,
                        at: cyc, lat: lat});
        done = 1;
      end
    end
    if (!done) miss("send32 accept timeout");
  endtask

  task automatic send32m(input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic [3:0] t,
                         input bit lat);
    exp_t e;
    e = model(32, 64'(a), 64'(b), c, t, lat);
    send32(a, b, c, t, e.s[31:0], e.c, e.o, lat);
  endtask

  task automatic idle32(input int n);
    repeat (n) begin
      @(negedge clk);
      v32 = 0;
    end
  endtask

  task automatic drain32();
    for (int k = 0; k < 40 && q32.size() > 0; k++) @(negedge clk);
    chk("drain32 left", 64'(q32.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("rst out_valid", 64'(ov32), 64'd0);
    chk("rst sum", 64'(s32), 64'd0);
    chk("rst cout", 64'(co32), 64'd0);
    chk("rst tag", 64'(to32), 64'd0);
    chk("rst in_ready", 64'(r32), 64'd1);
    chk("rst out_valid8", 64'(ov8), 64'd0);
    chk("rst out_valid64", 64'(ov64), 64'd0);

    send32(32'h12345678, 32'h11111111, 0, 4'd3,
           32'h23456789, 0, 0, 1);
    send32(32'hFFFFFFFF, 32'h00000000, 1, 4'd4,
           32'h00000000, 1, 0, 1);
    send32(32'h7FFFFFFF, 32'h00000001, 0, 4'd5,
           32'h80000000, 0, 1, 1);
    send32(32'h80000000, 32'h80000000, 0, 4'd6,
           32'h00000000, 1, 1, 1);
    send32(32'h00000000, 32'h00000000, 0, 4'd7,
           32'h00000000, 0, 0, 1);
    idle32(1);
    drain32();

    for (int i = 0; i < 8; i++)
      send32m(32'(i) * 32'h1F2E3D4C, 32'hF0F0F0F0 ^ 32'(i),
              1'(i), 4'(i), 1);
    idle32(1);
    drain32();

    @(negedge clk);
    v32 = 0; or32 = 0;
    send32(32'h00000001, 32'h00000002, 0, 4'd8,
           32'h00000003, 0, 0, 0);
    send32(32'hFFFF0000, 32'h00010000, 0, 4'd9,
           32'h00000000, 1, 0, 0);
    send32(32'h40000000, 32'h40000000, 0, 4'd10,
           32'h80000000, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      v32 = 0;
      #1;
      chk("stall in_ready", 64'(r32), 64'd0);
      chk("stall out_valid", 64'(ov32), 64'd1);
      chk("stall sum", 64'(s32), q32[0].s);
      chk("stall tag", 64'(to32), 64'(q32[0].t));
    end
    @(negedge clk);
    or32 = 1;
    send32(32'h00000005, 32'h00000005, 1, 4'd11,
           32'h0000000B, 0, 0, 0);
    idle32(1);
    drain32();

    @(negedge clk);
    or32 = 0;
    send32m(32'hAAAA5555, 32'h01020304, 1, 4'd12, 0);
    send32m(32'h0F0F0F0F, 32'hF0F0F0F0, 1, 4'd13, 0);
    send32m(32'hDEADBEEF, 32'h11111111, 0, 4'd14, 0);
    @(negedge clk);
    v32 = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    q32.delete();
    #1;
    chk("midrst out_valid", 64'(ov32), 64'd0);
    chk("midrst sum", 64'(s32), 64'd0);
    chk("midrst in_ready", 64'(r32), 64'd1);
    @(negedge clk);
    or32 = 1;
    idle32(8);
    send32(32'h12345678, 32'h11111111, 0, 4'd3,
           32'h23456789, 0, 0, 1);
    idle32(1);
    drain32();

    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      v8 = 1; a8 = 8'($urandom); b8 = 8'($urandom);
      ci8 = 1'($urandom); ti8 = 4'(k);
      or8 = ($urandom_range(0, 3) != 0);
      v64 = 1; a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
      ci64 = 1'($urandom); ti64 = 4'(k);
      or64 = ($urandom_range(0, 3) != 0);
      #1;
      if (r8)
        q8.push_back(model(8, 64'(a8), 64'(b8), ci8, ti8, 0));
      if (r64)
        q64.push_back(model(64, a64, b64, ci64, ti64, 0));
    end
    @(negedge clk);
    v8 = 0; v64 = 0; or8 = 1; or64 = 1;
    for (int k = 0; k < 40 && (q8.size() + q64.size()) > 0; k++)
      @(negedge clk);
    chk("drain8 left", 64'(q8.size()), 64'd0);
    chk("drain64 left", 64'(q64.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
